mem_port_arbiter: RTL and testbench

Shares one single-port synchronous memory between two requesters: instruction fetch (I port) and the MEM-stage load/store unit (D port). It arbitrates each cycle, drives the memory port, and tracks the read latency. It returns read data to the correct requester and generates stall requests for the hazard unit. It sits between the fetch/MEM pipeline stages and a unified BRAM, and replaces separate instruction and data memories.

---
 rtl/mem_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one single-port synchronous memory (fetch + load/store).
// Define ARB_ROUND_ROBIN_EN for alternating tie priority; otherwise D wins ties with a fetch starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 64,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall_if,
    output logic                  stall_mem
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] RD_WAIT = 1'b1;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

    logic [0:0]        state_reg, state_next;
    logic [2:0]        lat_cnt_reg, lat_cnt_next;
    logic              owner_reg, owner_next;
    logic              rv_pend_reg, rv_pend_next;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    logic grant_ok;
    logic i_pri;
    logic i_gnt_w;
    logic d_gnt_w;
    logic rd_gnt;
    logic wr_gnt;
    logic rvalid;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_winner_reg, last_winner_next;

    // Fetch takes a tie only when data won the previous grant.
    assign i_pri = (last_winner_reg == OWN_D);

    always_comb begin
        last_winner_next = last_winner_reg;
        if (i_gnt_w) begin
            last_winner_next = OWN_I;
        end else if (d_gnt_w) begin
            last_winner_next = OWN_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner_reg <= OWN_I;
        end else begin
            last_winner_reg <= last_winner_next;
        end
    end
`else
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    logic [SC_W-1:0] starve_cnt_reg, starve_cnt_next;

    assign i_pri = (starve_cnt_reg == STARVE_LIM);

    // Counts only cycles where fetch could have been served but lost.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (i_gnt_w) begin
            starve_cnt_next = '0;
        end else if (grant_ok && i_req && (starve_cnt_reg < STARVE_LIM)) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end
`endif

    assign grant_ok = ~reset & (state_reg == IDLE);
    assign i_gnt_w  = grant_ok & i_req & (~d_req | i_pri);
    assign d_gnt_w  = grant_ok & d_req & ~i_gnt_w;
    assign rd_gnt   = i_gnt_w | (d_gnt_w & ~d_we);
    assign wr_gnt   = d_gnt_w & d_we;

    assign i_gnt  = i_gnt_w;
    assign d_gnt  = d_gnt_w;
    assign mem_en = i_gnt_w | d_gnt_w;

    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane_we
            assign mem_we[gi] = wr_gnt & d_wstrb[gi];
        end
    endgenerate

    // Address and write data hold their last granted values when idle.
    always_comb begin
        mem_addr  = mem_addr_reg;
        mem_wdata = mem_wdata_reg;
        if (reset) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (i_gnt_w) begin
            mem_addr  = i_addr;
        end else if (d_gnt_w) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    assign rvalid   = rv_pend_reg & ~reset;
    assign i_rvalid = rvalid & (owner_reg == OWN_I);
    assign d_rvalid = rvalid & (owner_reg == OWN_D);
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

    assign stall_if  = ~reset & i_req & ~i_rvalid;
    assign stall_mem = ~reset & d_req & ~(d_gnt_w & d_we) & ~d_rvalid;

    // rv_pend_reg is set the cycle before rvalid, so the rvalid cycle is back in IDLE.
    always_comb begin
        state_next   = state_reg;
        lat_cnt_next = lat_cnt_reg;
        owner_next   = owner_reg;
        rv_pend_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rd_gnt) begin
                    owner_next = i_gnt_w ? OWN_I : OWN_D;
                    if (RD_LAT <= 1) begin
                        rv_pend_next = 1'b1;
                    end else begin
                        state_next   = RD_WAIT;
                        lat_cnt_next = LAT_INIT;
                    end
                end
            end
            RD_WAIT: begin
                if (lat_cnt_reg <= 3'd1) begin
                    state_next   = IDLE;
                    lat_cnt_next = '0;
                    rv_pend_next = 1'b1;
                end else begin
                    lat_cnt_next = lat_cnt_reg - 3'd1;
                end
            end
            default: begin
                state_next   = IDLE;
                lat_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            lat_cnt_reg   <= '0;
            owner_reg     <= OWN_I;
            rv_pend_reg   <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            lat_cnt_reg   <= lat_cnt_next;
            owner_reg     <= owner_next;
            rv_pend_reg   <= rv_pend_next;
            mem_addr_reg  <= mem_addr;
            mem_wdata_reg <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances with RD_LAT = 1, 2, 3 share one stimulus stream.
module tb_mem_port_arbiter;

    localparam int AW = 14;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [SW-1:0] d_wstrb;

    logic          i_gnt_a     [3];
    logic          i_rvalid_a  [3];
    logic [DW-1:0] i_rdata_a   [3];
    logic          d_gnt_a     [3];
    logic          d_rvalid_a  [3];
    logic [DW-1:0] d_rdata_a   [3];
    logic          mem_en_a    [3];
    logic [SW-1:0] mem_we_a    [3];
    logic [AW-1:0] mem_addr_a  [3];
    logic [DW-1:0] mem_wdata_a [3];
    logic          stall_if_a  [3];
    logic          stall_mem_a [3];

    int checks = 0;
    int errors = 0;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            mem_port_arbiter #(
                .ADDR_W(AW), .DATA_W(DW), .RD_LAT(gi + 1), .STARVE_MAX(4)
            ) u_dut (
                .clk(clk), .reset(reset),
                .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_a[gi]),
                .i_rvalid(i_rvalid_a[gi]), .i_rdata(i_rdata_a[gi]),
                .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
                .d_wstrb(d_wstrb), .d_gnt(d_gnt_a[gi]), .d_rvalid(d_rvalid_a[gi]),
                .d_rdata(d_rdata_a[gi]), .mem_en(mem_en_a[gi]), .mem_we(mem_we_a[gi]),
                .mem_addr(mem_addr_a[gi]), .mem_wdata(mem_wdata_a[gi]),
                .mem_rdata(mem_rdata), .stall_if(stall_if_a[gi]), .stall_mem(stall_mem_a[gi])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-18s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        cyc();
        // Reset cycle with both requests high: every output must stay low.
        i_req = 1'b1; i_addr = 14'h011; d_req = 1'b1; d_we = 1'b1; d_wstrb = 8'hFF;
        #1;
        chk("rst_i_gnt",     64'(i_gnt_a[0]),     64'd0);
        chk("rst_d_gnt",     64'(d_gnt_a[0]),     64'd0);
        chk("rst_mem_en",    64'(mem_en_a[0]),    64'd0);
        chk("rst_mem_we",    64'(mem_we_a[0]),    64'd0);
        chk("rst_mem_addr",  64'(mem_addr_a[0]),  64'd0);
        chk("rst_stall_if",  64'(stall_if_a[0]),  64'd0);
        chk("rst_stall_mem", 64'(stall_mem_a[0]), 64'd0);

        // Fetch read, RD_LAT=1, followed by a back-to-back fetch.
        do_reset();
        i_req = 1'b1; i_addr = 14'h010; mem_rdata = 64'h13;
        #1;
        chk("t1_i_gnt",     64'(i_gnt_a[0]),    64'd1);
        chk("t1_mem_en",    64'(mem_en_a[0]),   64'd1);
        chk("t1_mem_addr",  64'(mem_addr_a[0]), 64'h010);
        chk("t1_mem_we",    64'(mem_we_a[0]),   64'd0);
        chk("t1_stall_if0", 64'(stall_if_a[0]), 64'd1);
        chk("t1_rvalid0",   64'(i_rvalid_a[0]), 64'd0);
        chk("t1_rdata0",    i_rdata_a[0],       64'd0);
        cyc();
        i_addr = 14'h011;
        #1;
        chk("t1_rvalid1",   64'(i_rvalid_a[0]), 64'd1);
        chk("t1_rdata1",    i_rdata_a[0],       64'h13);
        chk("t1_stall_if1", 64'(stall_if_a[0]), 64'd0);
        chk("t1_b2b_gnt",   64'(i_gnt_a[0]),    64'd1);
        chk("t1_b2b_addr",  64'(mem_addr_a[0]), 64'h011);
        cyc();
        i_req = 1'b0; mem_rdata = 64'h77;
        #1;
        chk("t1_rvalid2",   64'(i_rvalid_a[0]), 64'd1);
        chk("t1_rdata2",    i_rdata_a[0],       64'h77);
        chk("t1_d_rvalid",  64'(d_rvalid_a[0]), 64'd0);
        chk("t1_idle_en",   64'(mem_en_a[0]),   64'd0);
        chk("t1_hold_addr", 64'(mem_addr_a[0]), 64'h011);

        // Data write: completes in the grant cycle, no rvalid.
        cyc();
        d_req = 1'b1; d_we = 1'b1; d_addr = 14'h020; d_wdata = 64'hDEADBEEF; d_wstrb = 8'h0F;
        #1;
        chk("t3_d_gnt",     64'(d_gnt_a[0]),     64'd1);
        chk("t3_mem_en",    64'(mem_en_a[0]),    64'd1);
        chk("t3_mem_we",    64'(mem_we_a[0]),    64'h0F);
        chk("t3_mem_addr",  64'(mem_addr_a[0]),  64'h020);
        chk("t3_mem_wdata", mem_wdata_a[0],      64'hDEADBEEF);
        chk("t3_stall_mem", 64'(stall_mem_a[0]), 64'd0);
        cyc();
        d_req = 1'b0; d_we = 1'b0; d_wdata = 64'h1234;
        #1;
        chk("t3_d_rvalid",  64'(d_rvalid_a[0]), 64'd0);
        chk("t3_idle_we",   64'(mem_we_a[0]),   64'd0);
        chk("t3_hold_addr", 64'(mem_addr_a[0]), 64'h020);
        chk("t3_hold_wd",   mem_wdata_a[0],     64'hDEADBEEF);

        // RD_LAT=2: simultaneous reads, D first, then I in D's rvalid cycle.
        do_reset();
        i_req = 1'b1; i_addr = 14'h010; d_req = 1'b1; d_we = 1'b0; d_addr = 14'h100;
        #1;
        chk("t2_d_gnt",     64'(d_gnt_a[1]),     64'd1);
        chk("t2_i_gnt",     64'(i_gnt_a[1]),     64'd0);
        chk("t2_mem_addr",  64'(mem_addr_a[1]),  64'h100);
        chk("t2_mem_we",    64'(mem_we_a[1]),    64'd0);
        chk("t2_stall_mem", 64'(stall_mem_a[1]), 64'd1);
        cyc();
        #1;
        chk("t2_wait_i_gnt", 64'(i_gnt_a[1]),    64'd0);
        chk("t2_wait_d_gnt", 64'(d_gnt_a[1]),    64'd0);
        chk("t2_wait_en",    64'(mem_en_a[1]),   64'd0);
        chk("t2_wait_rv",    64'(d_rvalid_a[1]), 64'd0);
        cyc();
        d_req = 1'b0; mem_rdata = 64'hAB;
        #1;
        chk("t2_d_rvalid",  64'(d_rvalid_a[1]), 64'd1);
        chk("t2_d_rdata",   d_rdata_a[1],       64'hAB);
        chk("t2_i_gnt2",    64'(i_gnt_a[1]),    64'd1);
        chk("t2_i_addr2",   64'(mem_addr_a[1]), 64'h010);
        chk("t2_i_rdata2",  i_rdata_a[1],       64'd0);
        cyc();
        #1;
        chk("t2_wait2_gnt", 64'(i_gnt_a[1]),    64'd0);
        chk("t2_wait2_rv",  64'(i_rvalid_a[1]), 64'd0);
        cyc();
        i_req = 1'b0; mem_rdata = 64'hCD;
        #1;
        chk("t2_i_rvalid",  64'(i_rvalid_a[1]), 64'd1);
        chk("t2_i_rdata",   i_rdata_a[1],       64'hCD);
        chk("t2_d_rvalid2", 64'(d_rvalid_a[1]), 64'd0);

`ifndef ARB_ROUND_ROBIN_EN
        // Starvation guard: four D wins then a forced I win, twice over.
        do_reset();
        i_req = 1'b1; i_addr = 14'h050;
        d_req = 1'b1; d_we = 1'b1; d_addr = 14'h060; d_wdata = 64'h55; d_wstrb = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) cyc();
            #1;
            chk($sformatf("t4_d_gnt_c%0d", c), 64'(d_gnt_a[0]), 64'(c < 4));
            chk($sformatf("t4_i_gnt_c%0d", c), 64'(i_gnt_a[0]), 64'(c == 4));
        end
        cyc();
        i_req = 1'b0;
        #1;
        chk("t4_i_rvalid", 64'(i_rvalid_a[0]), 64'd1);
        chk("t4_d_after",  64'(d_gnt_a[0]),    64'd1);
        cyc();
        i_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) cyc();
            #1;
            chk($sformatf("t4b_d_gnt_c%0d", c), 64'(d_gnt_a[0]), 64'(c < 4));
            chk($sformatf("t4b_i_gnt_c%0d", c), 64'(i_gnt_a[0]), 64'(c == 4));
        end
`endif

        // Read discarded by reset, RD_LAT=3.
        do_reset();
        i_req = 1'b1; i_addr = 14'h030;
        #1;
        chk("t5_i_gnt", 64'(i_gnt_a[2]), 64'd1);
        cyc();
        reset = 1'b1;
        #1;
        chk("t5_rst_i_gnt",  64'(i_gnt_a[2]),     64'd0);
        chk("t5_rst_rvalid", 64'(i_rvalid_a[2]),  64'd0);
        chk("t5_rst_en",     64'(mem_en_a[2]),    64'd0);
        chk("t5_rst_addr",   64'(mem_addr_a[2]),  64'd0);
        chk("t5_rst_stall",  64'(stall_if_a[2]),  64'd0);
        chk("t5_rst_rdata",  i_rdata_a[2],        64'd0);
        cyc();
        reset = 1'b0; i_addr = 14'h040;
        #1;
        chk("t5_new_gnt",  64'(i_gnt_a[2]),    64'd1);
        chk("t5_new_addr", 64'(mem_addr_a[2]), 64'h040);
        for (int c = 0; c < 2; c++) begin
            cyc();
            #1;
            chk($sformatf("t5_norv_c%0d", c), 64'(i_rvalid_a[2]), 64'd0);
            chk($sformatf("t5_nogn_c%0d", c), 64'(i_gnt_a[2]),    64'd0);
        end
        cyc();
        i_req = 1'b0; mem_rdata = 64'h5A;
        #1;
        chk("t5_rvalid", 64'(i_rvalid_a[2]), 64'd1);
        chk("t5_rdata",  i_rdata_a[2],       64'h5A);

        // Both ports reading continuously with RD_LAT=1.
        do_reset();
        i_req = 1'b1; i_addr = 14'h070; d_req = 1'b1; d_we = 1'b0; d_addr = 14'h080;
        mem_rdata = 64'h99;
`ifdef ARB_ROUND_ROBIN_EN
        for (int c = 0; c < 4; c++) begin
            if (c > 0) cyc();
            #1;
            chk($sformatf("t6_d_gnt_c%0d", c), 64'(d_gnt_a[0]), 64'(c % 2 == 0));
            chk($sformatf("t6_i_gnt_c%0d", c), 64'(i_gnt_a[0]), 64'(c % 2 == 1));
        end
`else
        for (int c = 0; c < 5; c++) begin
            if (c > 0) cyc();
            #1;
            chk($sformatf("t6_d_gnt_c%0d", c), 64'(d_gnt_a[0]),    64'(c < 4));
            chk($sformatf("t6_i_gnt_c%0d", c), 64'(i_gnt_a[0]),    64'(c == 4));
            chk($sformatf("t6_d_rv_c%0d", c),  64'(d_rvalid_a[0]), 64'(c > 0));
        end
`endif
        cyc();
        clear_inputs();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
